cover_toggle_collector: RTL and testbench



---
 rtl/cover_toggle_collector_pkg.sv | 26 ++
 rtl/cover_toggle_collector_prio_enc.sv | 29 ++
 rtl/cover_toggle_collector.sv | 138 +++++++++++++
 tb/tb_cover_toggle_collector.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cover_toggle_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cover_pkg
// Description : Shared types, constants and helpers for the cover collectors.
// Revision    : 1.0 - initial release
// ============================================================================
package cover_pkg;

  localparam int COVER_TOTAL_DEFAULT = 8065;

  // Index width needed to address every cover point; never narrower than 1.
  function automatic int cover_idx_w(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

  localparam int COVER_IDX_W_DEFAULT = cover_idx_w(COVER_TOTAL_DEFAULT);

  typedef logic [COVER_IDX_W_DEFAULT-1:0] cover_idx_t;

  typedef enum logic [0:0] {
    EMIT_EMPTY = 1'b0,
    EMIT_HOLD  = 1'b1
  } emit_state_e;

endpackage
`default_nettype wire

// File: rtl/cover_toggle_collector_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : cover_prio_enc
// Description : Combinational lowest-set-bit priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module cover_prio_enc
  import cover_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LANE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]  req,
  output logic              any,
  output logic [LANE_W-1:0] lane
);

  assign any = |req;

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    lane = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) lane = LANE_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cover_toggle_collector.sv
`default_nettype none
// ============================================================================
// Module      : cover_toggle_collector
// Description : Sticky per-lane toggle coverage with deduplicated, serialised
//               first-hit index reporting over a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module cover_toggle_collector
    import cover_pkg::*;
#(
    parameter int WIDTH       = 39,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = COVER_TOTAL_DEFAULT,
    parameter int IDX_W       = cover_idx_w(COVER_TOTAL),
    parameter int CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] valid,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [CNT_W-1:0] hit_count,
    output logic             all_covered
);

    localparam int              LANE_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W:0]  CNT_MAX = (CNT_W + 1)'(WIDTH);

    logic [WIDTH-1:0]  covered;
    logic [WIDTH-1:0]  pending;
    logic [WIDTH-1:0]  new_hits;
    logic [WIDTH-1:0]  take_mask;
    emit_state_e       state;
    logic              pick_any;
    logic [LANE_W-1:0] pick_lane;
    logic [IDX_W-1:0]  pick_index;
    logic              take;
    logic [CNT_W-1:0]  new_cnt;
    logic [CNT_W:0]    cnt_sum;
    logic [CNT_W-1:0]  cnt_next;

    assign new_hits = valid & ~covered;

    // Only the registered pending set is searched, so hits arriving this cycle
    // are never picked before they have been stored.
    cover_prio_enc #(
        .WIDTH  (WIDTH),
        .LANE_W (LANE_W)
    ) u_prio (
        .req  (pending),
        .any  (pick_any),
        .lane (pick_lane)
    );

    // A lane leaves pending when loaded from EMPTY or on a HOLD handshake.
    assign take       = pick_any & ((state == EMIT_EMPTY) | out_ready);
    assign take_mask  = take ? (WIDTH'(1) << pick_lane) : '0;
    assign pick_index = IDX_W'(COVER_INDEX) + IDX_W'(pick_lane);

    // Popcount of first-time hits this cycle.
    always_comb begin
        new_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            new_cnt = new_cnt + CNT_W'(new_hits[i]);
        end
    end

    assign cnt_sum  = {1'b0, hit_count} + {1'b0, new_cnt};
    assign cnt_next = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];

    // Sticky coverage, pending set and covered-count bookkeeping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            covered     <= '0;
            pending     <= '0;
            hit_count   <= '0;
            all_covered <= 1'b0;
        end else if (clear) begin
            covered     <= '0;
            pending     <= '0;
            hit_count   <= '0;
            all_covered <= 1'b0;
        end else begin
            covered     <= covered | valid;
            pending     <= (pending & ~take_mask) | new_hits;
            hit_count   <= cnt_next;
            all_covered <= ({1'b0, cnt_next} == CNT_MAX);
        end
    end

    // Emission FSM: holds one index until accepted, reloads on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= EMIT_EMPTY;
            out_valid <= 1'b0;
            out_index <= '0;
        end else if (clear) begin
            state     <= EMIT_EMPTY;
            out_valid <= 1'b0;
            out_index <= '0;
        end else begin
            case (state)
                EMIT_EMPTY: begin
                    if (take) begin
                        out_index <= pick_index;
                        out_valid <= 1'b1;
                        state     <= EMIT_HOLD;
                    end
                end
                EMIT_HOLD: begin
                    if (out_ready) begin
                        if (take) begin
                            out_index <= pick_index;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= EMIT_EMPTY;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= EMIT_EMPTY;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Distinct-lane count can never exceed the lane count.
    always_ff @(posedge clock) begin
        if (reset_n && !clear) assert (cnt_sum <= CNT_MAX);
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cover_toggle_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_cover_toggle_collector
// Description : Self-checking bench for cover_toggle_collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cover_toggle_collector;

  localparam int WIDTH = 39;
  localparam int CI    = 100;
  localparam int TOTAL = 8065;
  localparam int IDX_W = 13;
  localparam int CNT_W = 6;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] valid = '0;
  logic             clear = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [IDX_W-1:0] out_index;
  logic [CNT_W-1:0] hit_count;
  logic             all_covered;

  cover_toggle_collector #(
    .WIDTH       (WIDTH),
    .COVER_INDEX (CI),
    .COVER_TOTAL (TOTAL),
    .IDX_W       (IDX_W),
    .CNT_W       (CNT_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .valid       (valid),
    .clear       (clear),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
    .hit_count   (hit_count),
    .all_covered (all_covered)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int fails   = 0;

  // Reference model: sets of covered / waiting lanes plus the presented index.
  bit cov  [WIDTH];
  bit pend [WIDTH];
  bit m_valid;
  int m_idx;
  int m_cnt;
  int emitted[$];

  logic             s_valid = 1'b0;
  logic [IDX_W-1:0] s_index = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < WIDTH; i++) begin
      cov[i]  = 1'b0;
      pend[i] = 1'b0;
    end
    m_valid = 1'b0;
    m_idx   = 0;
    m_cnt   = 0;
  endfunction

  // One clock edge of the specified behaviour, from pre-edge state and inputs.
  function automatic void model_edge(input logic [WIDTH-1:0] v, input bit clr, input bit rdy);
    int low;
    if (clr) begin
      model_reset();
      return;
    end
    low = -1;
    for (int i = WIDTH - 1; i >= 0; i--) if (pend[i]) low = i;
    if (!m_valid || rdy) begin
      if (low >= 0) begin
        m_valid   = 1'b1;
        m_idx     = CI + low;
        pend[low] = 1'b0;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i] && !cov[i]) begin
        cov[i]  = 1'b1;
        pend[i] = 1'b1;
        m_cnt++;
      end
    end
  endfunction

  task automatic compare_all();
    check("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) check("out_index", 64'(out_index), 64'(m_idx));
    check("hit_count", 64'(hit_count), 64'(m_cnt));
    check("all_covered", 64'(all_covered), 64'(m_cnt == WIDTH));
    s_valid = out_valid;
    s_index = out_index;
  endtask

  task automatic tick(input logic [WIDTH-1:0] v, input bit clr, input bit rdy);
    valid     = v;
    clear     = clr;
    out_ready = rdy;
    @(posedge clock);
    if (s_valid && rdy) emitted.push_back(int'(s_index));
    model_edge(v, clr, rdy);
    @(negedge clock);
    compare_all();
  endtask

  initial begin
    logic [63:0]      r;
    logic [WIDTH-1:0] ones;
    ones = '1;
    model_reset();

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_index", 64'(out_index), 64'd0);
    check("rst_hit_count", 64'(hit_count), 64'd0);
    check("rst_all_covered", 64'(all_covered), 64'd0);
    reset_n = 1'b1;

    // Single hit on lane 5, then repeated hits produce nothing more
    tick(WIDTH'(1) << 5, 1'b0, 1'b1);
    check("single_not_yet", 64'(out_valid), 64'd0);
    tick('0, 1'b0, 1'b1);
    check("single_idx", 64'(out_index), 64'(CI + 5));
    check("single_cnt", 64'(hit_count), 64'd1);
    tick('0, 1'b0, 1'b1);
    repeat (10) tick(WIDTH'(1) << 5, 1'b0, 1'b1);
    repeat (3) tick('0, 1'b0, 1'b1);
    check("single_once", 64'(emitted.size()), 64'd1);

    // Burst on lanes 0,4,8
    tick('0, 1'b1, 1'b1);
    emitted.delete();
    tick(WIDTH'(39'h0_0000_0111), 1'b0, 1'b1);
    check("burst_cnt", 64'(hit_count), 64'd3);
    repeat (5) tick('0, 1'b0, 1'b1);
    check("burst_n", 64'(emitted.size()), 64'd3);
    if (emitted.size() == 3) begin
      check("burst_0", 64'(emitted[0]), 64'(CI + 0));
      check("burst_1", 64'(emitted[1]), 64'(CI + 4));
      check("burst_2", 64'(emitted[2]), 64'(CI + 8));
    end

    // Backpressure with two pending lanes
    tick('0, 1'b1, 1'b0);
    emitted.delete();
    tick((WIDTH'(1) << 2) | (WIDTH'(1) << 7), 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0);
    repeat (5) begin
      tick('0, 1'b0, 1'b0);
      check("bp_hold", 64'(out_index), 64'(CI + 2));
    end
    tick('0, 1'b0, 1'b1);
    tick('0, 1'b0, 1'b1);
    check("bp_drained", 64'(out_valid), 64'd0);
    check("bp_n", 64'(emitted.size()), 64'd2);
    if (emitted.size() == 2) check("bp_second", 64'(emitted[1]), 64'(CI + 7));

    // Clear while holding an unaccepted index, then lane 5 re-emits
    tick('0, 1'b1, 1'b0);
    tick(WIDTH'(1) << 3, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0);
    tick(WIDTH'(1) << 9, 1'b1, 1'b0);
    check("clr_valid", 64'(out_valid), 64'd0);
    check("clr_cnt", 64'(hit_count), 64'd0);
    tick(WIDTH'(1) << 5, 1'b0, 1'b1);
    tick('0, 1'b0, 1'b1);
    check("clr_reemit", 64'(out_index), 64'(CI + 5));

    // Full coverage
    tick('0, 1'b1, 1'b1);
    emitted.delete();
    tick(ones, 1'b0, 1'b1);
    check("full_cnt", 64'(hit_count), 64'(WIDTH));
    check("full_all", 64'(all_covered), 64'd1);
    repeat (45) tick(ones, 1'b0, 1'b1);
    check("full_n", 64'(emitted.size()), 64'(WIDTH));
    for (int i = 0; i < emitted.size(); i++) check("full_order", 64'(emitted[i]), 64'(CI + i));

    // Asynchronous reset in the middle of a burst
    tick('0, 1'b1, 1'b1);
    tick(WIDTH'(39'h7), 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_index", 64'(out_index), 64'd0);
    check("arst_cnt", 64'(hit_count), 64'd0);
    check("arst_all", 64'(all_covered), 64'd0);
    model_reset();
    s_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    emitted.delete();
    repeat (5) tick('0, 1'b0, 1'b1);
    check("arst_no_stale", 64'(emitted.size()), 64'd0);

    // Randomised traffic against the model
    repeat (600) begin
      r = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      tick(r[WIDTH-1:0], ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
